// File: rtl/seq_det_pkg.sv
// Shared constants and helpers for the serial pattern detector.
package seq_det_pkg;

  localparam int unsigned MATCH_CNT_W      = 16;
  localparam int unsigned DEF_DETECT_WIDTH = 5;
  localparam logic [DEF_DETECT_WIDTH-1:0] DEF_PATTERN = 5'b10110;

  // Width of a counter that must hold values 0..w inclusive.
  function automatic int unsigned fill_width(int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/seq_det_hist.sv
// Bit history shift register with a saturating fill counter; clr_i empties the fill
// count on the same edge that would otherwise load fill_nxt_c.
module seq_det_hist
  import seq_det_pkg::*;
#(
  parameter int unsigned W = DEF_DETECT_WIDTH,
  localparam int unsigned FW = fill_width(int'(W))
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          data_i,
  input  logic          clr_i,
  output logic [W-1:0]  hist_nxt_c,
  output logic [FW-1:0] fill_nxt_c
);

  logic [W-1:0]  hist_q;
  logic [FW-1:0] fill_q;

  // Next history / fill values as seen after the current edge.
  always_comb begin
    hist_nxt_c = {hist_q[W-2:0], data_i};
    fill_nxt_c = (fill_q == FW'(W)) ? fill_q : fill_q + FW'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hist_q <= '0;
      fill_q <= '0;
    end else begin
      hist_q <= hist_nxt_c;
      fill_q <= clr_i ? '0 : fill_nxt_c;
    end
  end

endmodule

// File: rtl/seq_pattern_detector.sv
// Serial pattern detector with overlapping/non-overlapping match modes.
// Optional saturating match counter on match_cnt_o when SEQ_DET_MATCH_CNT_EN is defined.
module seq_pattern_detector
  import seq_det_pkg::*;
#(
  parameter int unsigned               DETECT_WIDTH = DEF_DETECT_WIDTH,
  parameter logic [DETECT_WIDTH-1:0]   PATTERN      = DETECT_WIDTH'(DEF_PATTERN),
  parameter bit                        OVERLAPPING  = 1'b1
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   data_i,
  output logic                   detected_o
`ifdef SEQ_DET_MATCH_CNT_EN
  ,
  output logic [MATCH_CNT_W-1:0] match_cnt_o
`endif
);

  localparam int unsigned FW = fill_width(int'(DETECT_WIDTH));

  generate
    if (DETECT_WIDTH < 2 || DETECT_WIDTH > 32) begin : g_bad_width
      $error("seq_pattern_detector: DETECT_WIDTH must be in 2..32");
    end
  endgenerate

  logic [DETECT_WIDTH-1:0] hist_nxt_c;
  logic [FW-1:0]           fill_nxt_c;
  logic                    match_c;
  logic                    clr_c;

  seq_det_hist #(
    .W (DETECT_WIDTH)
  ) u_hist (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .data_i     (data_i),
    .clr_i      (clr_c),
    .hist_nxt_c (hist_nxt_c),
    .fill_nxt_c (fill_nxt_c)
  );

  // Fill gating keeps reset-state history from matching all-zero patterns.
  always_comb begin
    match_c = (fill_nxt_c == FW'(DETECT_WIDTH)) && (hist_nxt_c == PATTERN);
    clr_c   = match_c && !OVERLAPPING;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      detected_o <= 1'b0;
    end else begin
      detected_o <= match_c;
    end
  end

`ifdef SEQ_DET_MATCH_CNT_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      match_cnt_o <= '0;
    end else if (match_c && (match_cnt_o != '1)) begin
      match_cnt_o <= match_cnt_o + MATCH_CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_seq_pattern_detector.sv
// Bench for seq_pattern_detector: four configurations share one bit stream and are
// checked every cycle against a bit-queue model, plus directed literal expectations.
module tb_seq_pattern_detector;

  localparam int NCFG = 4;
  localparam int CW  [NCFG] = '{5, 5, 4, 4};
  localparam int CP  [NCFG] = '{22, 22, 0, 0};
  localparam int COV [NCFG] = '{1, 0, 1, 0};

  logic       clk = 1'b0;
  logic       rst_n;
  logic       data;
  logic [3:0] det;
`ifdef SEQ_DET_MATCH_CNT_EN
  logic [3:0][15:0] cnt;
`endif

  int n_checks = 0;
  int n_err    = 0;

  bit hq[$];
  int since   [NCFG];
  int mcnt    [NCFG];
  int exp_det [NCFG];

  always #5 clk = ~clk;

  seq_pattern_detector #(.DETECT_WIDTH(5), .PATTERN(5'b10110), .OVERLAPPING(1'b1)) u_ov (
    .clk_i(clk), .rst_ni(rst_n), .data_i(data), .detected_o(det[0])
`ifdef SEQ_DET_MATCH_CNT_EN
    , .match_cnt_o(cnt[0])
`endif
  );

  seq_pattern_detector #(.DETECT_WIDTH(5), .PATTERN(5'b10110), .OVERLAPPING(1'b0)) u_nov (
    .clk_i(clk), .rst_ni(rst_n), .data_i(data), .detected_o(det[1])
`ifdef SEQ_DET_MATCH_CNT_EN
    , .match_cnt_o(cnt[1])
`endif
  );

  seq_pattern_detector #(.DETECT_WIDTH(4), .PATTERN(4'b0000), .OVERLAPPING(1'b1)) u_z_ov (
    .clk_i(clk), .rst_ni(rst_n), .data_i(data), .detected_o(det[2])
`ifdef SEQ_DET_MATCH_CNT_EN
    , .match_cnt_o(cnt[2])
`endif
  );

  seq_pattern_detector #(.DETECT_WIDTH(4), .PATTERN(4'b0000), .OVERLAPPING(1'b0)) u_z_nov (
    .clk_i(clk), .rst_ni(rst_n), .data_i(data), .detected_o(det[3])
`ifdef SEQ_DET_MATCH_CNT_EN
    , .match_cnt_o(cnt[3])
`endif
  );

  task automatic check(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  // True when the most recent w received bits spell pat (pat bit 0 = newest bit).
  function automatic bit tail_ok(input int w, input int pat);
    if (hq.size() < w) return 1'b0;
    for (int i = 0; i < w; i++)
      if (hq[hq.size() - 1 - i] != pat[i]) return 1'b0;
    return 1'b1;
  endfunction

  // Reference model: every bit since reset is kept; 'since' counts bits usable for the next match.
  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        hq.delete();
        for (int k = 0; k < NCFG; k++) begin
          since[k] = 0; mcnt[k] = 0; exp_det[k] = 0;
        end
      end else begin
        hq.push_back(data);
        for (int k = 0; k < NCFG; k++) begin
          since[k]++;
          exp_det[k] = (since[k] >= CW[k] && tail_ok(CW[k], CP[k])) ? 1 : 0;
          if (exp_det[k] == 1) begin
            if (mcnt[k] < 65535) mcnt[k]++;
            if (COV[k] == 0) since[k] = 0;
          end
        end
      end
    end
  end

  // Cycle-by-cycle comparison on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      for (int k = 0; k < NCFG; k++) begin
        check($sformatf("det_cfg%0d", k), int'(det[k]), exp_det[k]);
`ifdef SEQ_DET_MATCH_CNT_EN
        check($sformatf("cnt_cfg%0d", k), int'(cnt[k]), mcnt[k]);
`endif
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic send(input bit b);
    data = b;
    @(negedge clk);
  endtask

  task automatic pulse_reset();
    #2 rst_n = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    logic [7:0] bits8, exp_ov8, exp_nov8;
    logic [4:0] bits5;
    rst_n = 1'b0;
    data  = 1'b0;
    repeat (10) @(negedge clk);
    for (int k = 0; k < NCFG; k++) begin
      check("reset_det", int'(det[k]), 0);
`ifdef SEQ_DET_MATCH_CNT_EN
      check("reset_cnt", int'(cnt[k]), 0);
`endif
    end
    #2 rst_n = 1'b1;

    // Zeros after reset: no 10110 pulse; all-zero pattern fires once fill is full.
    for (int i = 1; i <= 8; i++) begin
      send(1'b0);
      check("zeros_no_pulse", int'(det[0]), 0);
      check("zero_pat_ov", int'(det[2]), (i >= 4) ? 1 : 0);
      check("zero_pat_nov", int'(det[3]), (i % 4 == 0) ? 1 : 0);
      check("model_zero_nov", exp_det[3], (i % 4 == 0) ? 1 : 0);
    end

    // Overlapping versus non-overlapping on 1,0,1,1,0,1,1,0.
    pulse_reset();
    bits8 = 8'b1011_0110; exp_ov8 = 8'b0000_1001; exp_nov8 = 8'b0000_1000;
    for (int i = 7; i >= 0; i--) begin
      send(bits8[i]);
      check("overlap", int'(det[0]), int'(exp_ov8[i]));
      check("nonoverlap", int'(det[1]), int'(exp_nov8[i]));
      check("model_overlap", exp_det[0], int'(exp_ov8[i]));
    end
    send(1'b0);
    check("pulse_one_cycle_ov", int'(det[0]), 0);
    check("pulse_one_cycle_nov", int'(det[1]), 0);
`ifdef SEQ_DET_MATCH_CNT_EN
    check("cnt_overlap", int'(cnt[0]), 2);
    check("cnt_nonoverlap", int'(cnt[1]), 1);
`endif

    // Single match, then reset while the pulse is high.
    pulse_reset();
    bits5 = 5'b10110;
    for (int i = 4; i >= 0; i--) send(bits5[i]);
    check("single_match", int'(det[0]), 1);
    #2 rst_n = 1'b0;
    #1 check("reset_drops_pulse", int'(det[0]), 0);
    @(negedge clk);
    #2 rst_n = 1'b1;

    // Partial pattern discarded by reset: 1,0,1 | reset | 1,0 must not match.
    send(1'b1); send(1'b0); send(1'b1);
    pulse_reset();
    send(1'b1);
    check("mid_reset_a", int'(det[0]), 0);
    send(1'b0);
    check("mid_reset_b", int'(det[0]), 0);
    send(1'b1);
    send(1'b1);
    check("mid_reset_c", int'(det[0]), 0);
    send(1'b0);
    check("mid_reset_fresh_match", int'(det[0]), 1);
`ifdef SEQ_DET_MATCH_CNT_EN
    check("cnt_after_reset", int'(cnt[0]), 1);
`endif

    // Random stream with one reset in the middle.
    for (int i = 0; i < 1000; i++) begin
      if (i == 500) pulse_reset();
      send(1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
